roce_write_seq_ctrl: RTL and testbench
======================================

# roce_write_seq_ctrl

Sequencer for RDMA WRITE transfers on one RC queue pair. It accepts a transfer request carrying the QP context, segments the transfer into PMTU-sized packets, and issues BTH/RETH header beats to the TX header path. It then waits for the ACK/NAK reported by the QP state logic and retransmits the whole message on NAK or timeout (go-back-to-first-PSN). It sits between the host/DMA control and the RoCE TX header generator.

## Interface
Parameters:
- PMTU_LOG2, 10: log2 of path MTU in bytes (8..12).
- TIMEOUT_CYCLES, 65536: ACK wait limit, in cycles; must be ≥2.
- MAX_RETRY, 7: retransmissions allowed before error.

Ports (clk/rst_n share the codebase clock and reset names; the reset signal is active-low):
- clk  in  1  clock.
- rst_n  in  1  reset, **asynchronous, active-low**.
- s_req_valid / s_req_ready  in/out  1  transfer request handshake.
- s_req_length  in  32  total bytes.
- s_req_v_addr  in  64  remote virtual address.
- s_req_r_key  in  32  remote key.
- s_req_dest_qp  in  24  remote QPN.
- s_req_psn  in  24  first PSN.
- m_bth_valid / m_bth_ready  out/in  1  header beat handshake.
- m_bth_op_code  out  8  0x06 / 0x07 / 0x08 / 0x0A.
- m_bth_psn  out  24  packet PSN.
- m_bth_dest_qp  out  24  = latched dest QP.
- m_bth_ack_req  out  1  1 on LAST/ONLY only.
- m_reth_valid  out  1  1 on FIRST/ONLY beats.
- m_reth_v_addr  out  64  RETH virtual address.
- m_reth_r_key  out  32  RETH remote key.
- m_reth_length  out  32  RETH length (total).
- m_pkt_length  out  14  payload bytes of this packet.
- s_ack_valid  in  1  ACK/NAK event.
- s_ack_nak  in  1  syndrome[6:5]≠0.
- s_ack_psn  in  24  acknowledged PSN.
- busy  out  1  request in progress.
- done  out  1  one-cycle pulse on success.
- error  out  1  one-cycle pulse on retry exhaustion.
- next_psn  out  24  last PSN+1, valid with done.
- retry_count  out  3  retries so far.

## Operation
States:
- IDLE: s_req_ready=1. On handshake, latch all request fields and compute n_pkts=ceil(length/PMTU) (length 0 → 1), last_len=length−(n_pkts−1)·PMTU, last_psn=(psn+n_pkts−1) mod 2^24, go to SEND.
- SEND: pkt_idx counts 0..n_pkts−1.
  - Opcode: n_pkts=1 → ONLY; idx 0 → FIRST; idx n_pkts−1 → LAST; otherwise MIDDLE.
  - psn=(start_psn+idx) mod 2^24.
  - m_pkt_length: PMTU, except last_len on the final packet.
  - RETH fields are always the latched request values.
  - After the final beat is accepted, go to WAIT_ACK and clear the timer.
- WAIT_ACK:
  - s_ack_valid with nak=0 and psn==last_psn → DONE.
  - ACK with another PSN is ignored.
  - nak=1 (any PSN), or timer reaching TIMEOUT_CYCLES−1 → RETRY.
- RETRY: if retry_count==MAX_RETRY → ERR. Otherwise increment retry_count, set idx=0, return to SEND. Same PSNs are reused.
- DONE: done=1 and next_psn=last_psn+1 (mod 2^24) for one cycle, then IDLE. retry_count clears on the next accept.
- ERR: error=1 for one cycle, then IDLE.

ACK events outside WAIT_ACK are dropped. Arithmetic uses 32-bit lengths; PSN wraps 0xFFFFFF→0x000000.

## Timing
- Reset values: s_req_ready=0 during reset, 1 from the first cycle after release. m_bth_valid=0, m_reth_valid=0, done=0, error=0, busy=0, retry_count=0, next_psn=0, all header fields 0.
- First header valid on the cycle after request accept.
- AXI-style handshake: valid is held, and fields are stable, until ready. One beat per cycle at full throughput. Valid is never dropped without ready.
- WAIT_ACK begins on the cycle after the final beat transfers.
- ACK → done latency is 1 cycle. Timeout/NAK → first retransmitted beat valid after 2 cycles (RETRY, then SEND).
- busy=1 from the accept cycle through the DONE/ERR cycle inclusive.
- Reset asserted mid-transfer aborts immediately with no done/error pulse.
- If an ACK and a timeout hit the same cycle, the matching ACK wins.

## Structure
- Shared package (roce_pkg) holds the RC opcode constants 0x06–0x0B and 0x11, plus the 24-bit PSN width.
- One natural sub-module: roce_pkt_segmenter, which computes n_pkts, last_len and per-index opcode/length combinationally from the latched request.
- The FSM, timer and retry counter stay in the top module.

## Test plan
- length=4096, PMTU=1024, psn=0x000010 → 4 beats FIRST/MIDDLE/MIDDLE/LAST, PSNs 0x10..0x13. RETH only on beat 0, ack_req only on beat 3. ACK psn 0x13 → done, next_psn=0x14.
- length=100 → single ONLY beat: pkt_length=100, reth_valid=1, ack_req=1. length=0 → ONLY with pkt_length=0.
- length=2500, psn=0xFFFFFE → PSNs 0xFFFFFE, 0xFFFFFF, 0x000000. last pkt_length=452. next_psn=0x000001.
- NAK after the first send → identical 3-beat resend, retry_count=1. Then a matching ACK → done.
- No ACK, MAX_RETRY=2 → two retransmissions, each TIMEOUT_CYCLES apart. Then an error pulse and return to IDLE.
- m_bth_ready held low 5 cycles mid-message → fields stable, no beat lost. rst_n pulsed mid-SEND → all outputs at reset values and no done/error pulse.

Source files
------------

// File: rtl/roce_pkg.sv
// roce_pkg: RoCE RC WRITE/ACK opcodes, PSN width and sequencer state encoding.
package roce_pkg;
  localparam int PSN_W = 24;
  localparam logic [7:0] OP_WR_FIRST = 8'h06;
  localparam logic [7:0] OP_WR_MIDDLE = 8'h07;
  localparam logic [7:0] OP_WR_LAST = 8'h08;
  localparam logic [7:0] OP_WR_LAST_IMM = 8'h09;
  localparam logic [7:0] OP_WR_ONLY = 8'h0A;
  localparam logic [7:0] OP_WR_ONLY_IMM = 8'h0B;
  localparam logic [7:0] OP_ACK = 8'h11;
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_ACK, S_RETRY, S_DONE, S_ERR} state_t;
endpackage

// File: rtl/roce_pkt_segmenter.sv
// roce_pkt_segmenter: packet count, per-index opcode and payload length for one WRITE message.
//   length   total message bytes        idx        current packet index
//   op_code  RC WRITE opcode for idx    pkt_length payload bytes of packet idx
//   last_idx n_pkts-1 (mod 2^24)        is_first/is_last  idx position flags
module roce_pkt_segmenter import roce_pkg::*; #(
  parameter int PMTU_LOG2 = 10
) (
  input  logic [31:0]      length,
  input  logic [31:0]      idx,
  output logic [7:0]       op_code,
  output logic [13:0]      pkt_length,
  output logic [PSN_W-1:0] last_idx,
  output logic             is_first,
  output logic             is_last
);
  localparam logic [13:0] PMTU = 14'(1 << PMTU_LOG2);
  logic [PMTU_LOG2-1:0] rem;
  logic [31:0] n_pkts;
  always_comb begin
    rem = length[PMTU_LOG2-1:0];
    // a partial tail adds one packet; an empty message still sends one ONLY packet
    n_pkts = 32'(length[31:PMTU_LOG2]) + 32'(rem != '0 || length == '0);
    is_first = idx == '0;
    is_last = idx == n_pkts - 32'd1;
    last_idx = PSN_W'(n_pkts - 32'd1);
    op_code = n_pkts == 32'd1 ? OP_WR_ONLY : is_first ? OP_WR_FIRST : is_last ? OP_WR_LAST : OP_WR_MIDDLE;
    pkt_length = !is_last ? PMTU : (rem == '0 && length != '0) ? PMTU : 14'(rem);
  end
endmodule

// File: rtl/roce_write_seq_ctrl.sv
// roce_write_seq_ctrl: RC RDMA WRITE sequencer with go-back-to-first-PSN retransmission.
//   s_req_*   transfer request (length, remote VA, rkey, dest QP, first PSN)
//   m_bth_*   BTH header beats; m_reth_* RETH fields, valid on FIRST/ONLY beats
//   s_ack_*   ACK/NAK events from QP state logic
//   busy/done/error/next_psn/retry_count  transfer status
module roce_write_seq_ctrl import roce_pkg::*; #(
  parameter int PMTU_LOG2 = 10,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRY = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_req_valid,
  output logic             s_req_ready,
  input  logic [31:0]      s_req_length,
  input  logic [63:0]      s_req_v_addr,
  input  logic [31:0]      s_req_r_key,
  input  logic [PSN_W-1:0] s_req_dest_qp,
  input  logic [PSN_W-1:0] s_req_psn,
  output logic             m_bth_valid,
  input  logic             m_bth_ready,
  output logic [7:0]       m_bth_op_code,
  output logic [PSN_W-1:0] m_bth_psn,
  output logic [PSN_W-1:0] m_bth_dest_qp,
  output logic             m_bth_ack_req,
  output logic             m_reth_valid,
  output logic [63:0]      m_reth_v_addr,
  output logic [31:0]      m_reth_r_key,
  output logic [31:0]      m_reth_length,
  output logic [13:0]      m_pkt_length,
  input  logic             s_ack_valid,
  input  logic             s_ack_nak,
  input  logic [PSN_W-1:0] s_ack_psn,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [PSN_W-1:0] next_psn,
  output logic [2:0]       retry_count
);
  state_t state;
  logic [31:0] len_q, rkey_q, idx, timer;
  logic [63:0] va_q;
  logic [PSN_W-1:0] dq_q, psn_q, last_idx, last_psn;
  logic [7:0] seg_op;
  logic [13:0] seg_len;
  logic seg_first, seg_last, sending;
  roce_pkt_segmenter #(.PMTU_LOG2(PMTU_LOG2)) u_seg (
    .length(len_q), .idx(idx), .op_code(seg_op), .pkt_length(seg_len),
    .last_idx(last_idx), .is_first(seg_first), .is_last(seg_last)
  );
  always_comb begin
    sending = state == S_SEND;
    last_psn = psn_q + last_idx;
    m_bth_valid = sending;
    m_bth_op_code = sending ? seg_op : '0;
    m_bth_psn = sending ? psn_q + idx[PSN_W-1:0] : '0;
    m_bth_dest_qp = dq_q;
    m_bth_ack_req = sending && seg_last;
    m_reth_valid = sending && seg_first;
    m_reth_v_addr = va_q;
    m_reth_r_key = rkey_q;
    m_reth_length = len_q;
    m_pkt_length = sending ? seg_len : '0;
    // busy covers the accept cycle itself, before the FSM leaves IDLE
    busy = state != S_IDLE || (s_req_valid && s_req_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      s_req_ready <= 1'b0;
      len_q <= '0;
      rkey_q <= '0;
      va_q <= '0;
      dq_q <= '0;
      psn_q <= '0;
      idx <= '0;
      timer <= '0;
      retry_count <= '0;
      done <= 1'b0;
      error <= 1'b0;
      next_psn <= '0;
    end else begin
      done <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (s_req_valid && s_req_ready) begin
            len_q <= s_req_length;
            va_q <= s_req_v_addr;
            rkey_q <= s_req_r_key;
            dq_q <= s_req_dest_qp;
            psn_q <= s_req_psn;
            idx <= '0;
            retry_count <= '0;
            s_req_ready <= 1'b0;
            state <= S_SEND;
          end else s_req_ready <= 1'b1;
        end
        S_SEND: begin
          if (m_bth_ready) begin
            if (seg_last) begin
              state <= S_WAIT_ACK;
              timer <= '0;
            end else idx <= idx + 32'd1;
          end
        end
        S_WAIT_ACK: begin
          // a matching ACK takes priority over a simultaneous timeout
          if (s_ack_valid && !s_ack_nak && s_ack_psn == last_psn) begin
            state <= S_DONE;
            done <= 1'b1;
            next_psn <= last_psn + 24'd1;
          end else if ((s_ack_valid && s_ack_nak) || timer == 32'(TIMEOUT_CYCLES - 1)) state <= S_RETRY;
          else timer <= timer + 32'd1;
        end
        S_RETRY: begin
          if (retry_count == 3'(MAX_RETRY)) begin
            state <= S_ERR;
            error <= 1'b1;
          end else begin
            retry_count <= retry_count + 3'd1;
            idx <= '0;
            state <= S_SEND;
          end
        end
        S_DONE, S_ERR: begin
          state <= S_IDLE;
          s_req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_roce_write_seq_ctrl.sv
// tb_roce_write_seq_ctrl: directed stimulus with a per-cycle beat model for roce_write_seq_ctrl.
module tb_roce_write_seq_ctrl;
  localparam int T = 20, MR = 2, PMTU = 1024;
  logic clk = 0, rst_n = 0;
  logic s_req_valid = 0, s_req_ready;
  logic [31:0] s_req_length = 0, s_req_r_key = 0;
  logic [63:0] s_req_v_addr = 0;
  logic [23:0] s_req_dest_qp = 0, s_req_psn = 0;
  logic m_bth_valid, m_bth_ready = 1, m_bth_ack_req, m_reth_valid;
  logic [7:0] m_bth_op_code;
  logic [23:0] m_bth_psn, m_bth_dest_qp;
  logic [63:0] m_reth_v_addr;
  logic [31:0] m_reth_r_key, m_reth_length;
  logic [13:0] m_pkt_length;
  logic s_ack_valid = 0, s_ack_nak = 0;
  logic [23:0] s_ack_psn = 0;
  logic busy, done, error;
  logic [23:0] next_psn;
  logic [2:0] retry_count;
  roce_write_seq_ctrl #(.PMTU_LOG2(10), .TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_length(s_req_length), .s_req_v_addr(s_req_v_addr), .s_req_r_key(s_req_r_key),
    .s_req_dest_qp(s_req_dest_qp), .s_req_psn(s_req_psn), .m_bth_valid(m_bth_valid),
    .m_bth_ready(m_bth_ready), .m_bth_op_code(m_bth_op_code), .m_bth_psn(m_bth_psn),
    .m_bth_dest_qp(m_bth_dest_qp), .m_bth_ack_req(m_bth_ack_req), .m_reth_valid(m_reth_valid),
    .m_reth_v_addr(m_reth_v_addr), .m_reth_r_key(m_reth_r_key), .m_reth_length(m_reth_length),
    .m_pkt_length(m_pkt_length), .s_ack_valid(s_ack_valid), .s_ack_nak(s_ack_nak),
    .s_ack_psn(s_ack_psn), .busy(busy), .done(done), .error(error), .next_psn(next_psn),
    .retry_count(retry_count)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [7:0] e_op[16];
  logic [23:0] e_psn[16];
  logic [13:0] e_len[16];
  int beat_cyc[16];
  int n_exp = 1, ptr = 0, cyc = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0;
  bit active = 0;
  logic [31:0] m_len = 0, m_rkey = 0;
  logic [63:0] m_va = 0;
  logic [23:0] m_dq = 0;
  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic build(input logic [31:0] len, input logic [63:0] va, input logic [31:0] rk,
                       input logic [23:0] dq, input logic [23:0] psn);
    int n;
    n = (len == 0) ? 1 : int'((64'(len) + 64'(PMTU - 1)) / 64'(PMTU));
    for (int i = 0; i < n && i < 16; i++) begin
      e_op[i] = n == 1 ? 8'h0A : i == 0 ? 8'h06 : i == n - 1 ? 8'h08 : 8'h07;
      e_psn[i] = 24'(psn + i);
      e_len[i] = 14'(i == n - 1 ? int'(len) - (n - 1) * PMTU : PMTU);
    end
    n_exp = n;
    ptr = 0;
    active = 1;
    m_len = len;
    m_va = va;
    m_rkey = rk;
    m_dq = dq;
  endtask
  initial begin
    int k;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) active = 0;
      else if (!active) chk("no_beat_when_idle", m_bth_valid, 1'b0);
      else if (m_bth_valid) begin
        k = ptr % n_exp;
        chk("beat", {m_bth_op_code, m_bth_psn, m_pkt_length, m_reth_valid, m_bth_ack_req, m_bth_dest_qp,
                     m_reth_v_addr, m_reth_r_key, m_reth_length},
                    {e_op[k], e_psn[k], e_len[k], 1'(k == 0), 1'(k == n_exp - 1), m_dq, m_va, m_rkey, m_len});
        if (m_bth_ready) begin
          if (ptr < 16) beat_cyc[ptr] = cyc;
          ptr++;
        end
      end
      if (done) begin
        done_cnt++;
        active = 0;
      end
      if (error) begin
        err_cnt++;
        err_cyc = cyc;
        active = 0;
      end
    end
  end
  task automatic chk_reset(input string nm);
    chk(nm, {s_req_ready, m_bth_valid, m_reth_valid, done, error, busy, retry_count, next_psn, m_bth_op_code,
             m_bth_psn, m_pkt_length, m_bth_ack_req, m_bth_dest_qp, m_reth_v_addr, m_reth_r_key, m_reth_length}, '0);
  endtask
  task automatic send_req(input logic [31:0] len, input logic [63:0] va, input logic [31:0] rk,
                          input logic [23:0] dq, input logic [23:0] psn);
    bit ok = 0;
    @(posedge clk); #1;
    s_req_valid = 1;
    s_req_length = len;
    s_req_v_addr = va;
    s_req_r_key = rk;
    s_req_dest_qp = dq;
    s_req_psn = psn;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #1;
      if (s_req_ready) ok = 1;
    end
    chk("req_accept", ok, 1'b1);
    if (ok) begin
      chk("busy_on_accept", busy, 1'b1);
      build(len, va, rk, dq, psn);
    end
    @(posedge clk); #1;
    s_req_valid = 0;
  endtask
  task automatic wait_ptr(input int k);
    for (int i = 0; i < 200 && ptr < k; i++) begin
      @(negedge clk); #1;
    end
    chk("beat_count", ptr, k);
  endtask
  task automatic send_ack(input logic [23:0] psn, input bit nak);
    @(posedge clk); #1;
    s_ack_valid = 1;
    s_ack_psn = psn;
    s_ack_nak = nak;
    @(posedge clk); #1;
    s_ack_valid = 0;
    s_ack_nak = 0;
  endtask
  task automatic expect_done(input logic [23:0] nxt);
    @(negedge clk); #1;
    chk("done_pulse", {done, busy, next_psn}, {2'b11, nxt});
    @(negedge clk); #1;
    chk("done_one_cycle", {done, busy}, 2'b00);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    int p, nak_cyc, d0, e0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset("reset_vals");
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("ready_after_reset", s_req_ready, 1'b1);
    // 4 full packets with a 5-cycle stall and an ACK arriving during SEND
    send_req(4096, 64'h1122334455667788, 32'hCAFEF00D, 24'hABCDEF, 24'h000010);
    chk("pin_t1_op0", e_op[0], 8'h06);
    chk("pin_t1_op3", e_op[3], 8'h08);
    chk("pin_t1_psn3", e_psn[3], 24'h000013);
    chk("pin_t1_len3", e_len[3], 14'd1024);
    wait_ptr(2);
    @(posedge clk); #1;
    m_bth_ready = 0;
    @(negedge clk); #1;
    p = ptr;
    send_ack(24'h000013, 0);
    repeat (3) @(posedge clk);
    #1;
    m_bth_ready = 1;
    chk("stall_no_beat", ptr, p);
    wait_ptr(4);
    send_ack(24'h000012, 0);
    @(negedge clk); #1;
    chk("ack_other_psn_ignored", {done, busy}, 2'b01);
    send_ack(24'h000013, 0);
    expect_done(24'h000014);
    // single ONLY packets
    send_req(100, 64'h00000000000000A0, 32'h00000001, 24'h000005, 24'h000005);
    chk("pin_t2_op", e_op[0], 8'h0A);
    chk("pin_t2_len", e_len[0], 14'd100);
    wait_ptr(1);
    send_ack(24'h000005, 0);
    expect_done(24'h000006);
    send_req(0, 64'h00000000000000B0, 32'h00000002, 24'h000006, 24'h000007);
    chk("pin_t3_len", e_len[0], 14'd0);
    wait_ptr(1);
    send_ack(24'h000007, 0);
    expect_done(24'h000008);
    // PSN wrap, NAK and identical resend
    send_req(2500, 64'hDEAD_BEEF_0000_1000, 32'h12345678, 24'h000777, 24'hFFFFFE);
    chk("pin_t4_psn1", e_psn[1], 24'hFFFFFF);
    chk("pin_t4_psn2", e_psn[2], 24'h000000);
    chk("pin_t4_len2", e_len[2], 14'd452);
    wait_ptr(3);
    send_ack(24'h000005, 1);
    nak_cyc = cyc;
    wait_ptr(6);
    chk("nak_to_resend", beat_cyc[3] - nak_cyc, 2);
    chk("retry_after_nak", retry_count, 3'd1);
    send_ack(24'h000000, 0);
    expect_done(24'h000001);
    // no ACK at all: MR retransmissions, then error
    send_req(2048, 64'h0000000000002000, 32'h0000AAAA, 24'h000100, 24'h000100);
    wait_ptr(2);
    for (int i = 0; i < 300 && !error; i++) begin
      @(negedge clk); #1;
    end
    chk("error_pulse", {error, busy, retry_count}, {2'b11, 3'(MR)});
    chk("beats_before_error", ptr, 2 * (MR + 1));
    chk("retry_gap_1", beat_cyc[2] - beat_cyc[0], 2 + T + 1);
    chk("retry_gap_2", beat_cyc[4] - beat_cyc[2], 2 + T + 1);
    chk("error_latency", err_cyc - beat_cyc[5], T + 2);
    @(negedge clk); #1;
    chk("idle_after_error", {busy, error, s_req_ready}, 3'b001);
    // reset in the middle of SEND
    send_req(4096, 64'h0000000000003000, 32'h0000BBBB, 24'h000200, 24'h000200);
    wait_ptr(1);
    d0 = done_cnt;
    e0 = err_cnt;
    @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk); #1;
    chk_reset("reset_mid_send");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (30) @(negedge clk);
    #1;
    chk("no_pulse_after_reset", {done_cnt, err_cnt}, {d0, e0});
    chk("ready_after_mid_reset", {s_req_ready, busy}, 2'b10);
    // ACK while idle is dropped; the transfer still needs its own ACK
    send_ack(24'h000300, 0);
    send_req(1024, 64'h0000000000004000, 32'h0000CCCC, 24'h000300, 24'h000300);
    chk("pin_t7_op", e_op[0], 8'h0A);
    chk("pin_t7_len", e_len[0], 14'd1024);
    wait_ptr(1);
    repeat (3) @(negedge clk);
    #1;
    chk("no_done_before_ack", {done, busy}, 2'b01);
    send_ack(24'h000300, 0);
    expect_done(24'h000301);
    chk("total_pulses", {done_cnt, err_cnt}, {32'd5, 32'd1});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
